// File: rtl/module_pool_array.sv
// module_pool_array
// Two-stage pipelined 2x2 pooling over CH parallel channels, with
// selectable max / rounded-average mode, a per-beat padding override
// and valid/ready flow control.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_ready = out_ready || !out_valid
//   ifm_win2x2      CH windows of 4 pixels; channel c at [c*4*DW +: 4*DW],
//                   pixel p at [p*DW +: DW] (p0 TL, p1 TR, p2 BL, p3 BR)
//   pool_mode       0 = max, 1 = rounded average (captured with the beat)
//   pool_zero_out   force the beat's output to zero_point (captured)
//   zero_point      quantisation zero point (captured)
//   out_valid/ready output handshake
//   ofm_stream      CH pooled bytes; channel c at [c*DW +: DW]

// Per-channel datapath. S1 reduces the window to two pair values; S2
// combines the pairs, or substitutes the zero point.
module module_pool_lane #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ld1,      // S1 captures a new beat
  input  logic          i_ld2,      // S2 captures the S1 beat
  input  logic [4*DW-1:0] i_win,
  input  logic          i_mode,     // mode of the beat entering S1
  input  logic          i_s1_mode,  // captured mode of the beat in S1
  input  logic          i_s1_zo,
  input  logic [DW-1:0] i_s1_zp,
  output logic [DW-1:0] o_res
);
  logic [DW-1:0] w_p0, w_p1, w_p2, w_p3;
  logic [DW:0]   w_a, w_b;
  logic [DW:0]   r_a, r_b;
  logic [DW+1:0] w_sum;
  logic [DW-1:0] w_max, w_res;
  logic [DW-1:0] r_res;

  assign w_p0 = i_win[0*DW +: DW];
  assign w_p1 = i_win[1*DW +: DW];
  assign w_p2 = i_win[2*DW +: DW];
  assign w_p3 = i_win[3*DW +: DW];

  // One shared DW+1 field per pair: pair sum in avg mode, pair max
  // (zero-extended) in max mode.
  assign w_a = i_mode ? ({1'b0, w_p0} + {1'b0, w_p1})
                      : {1'b0, (w_p0 > w_p1) ? w_p0 : w_p1};
  assign w_b = i_mode ? ({1'b0, w_p2} + {1'b0, w_p3})
                      : {1'b0, (w_p2 > w_p3) ? w_p2 : w_p3};

  // +2 before >>2 rounds half up; four DW-bit values plus 2 fit in DW+2
  // bits and the quotient never exceeds the DW-bit maximum.
  assign w_sum = {1'b0, r_a} + {1'b0, r_b} + (DW+2)'(2);
  // In max mode the top bit of both pair fields is zero.
  assign w_max = (r_a[DW-1:0] > r_b[DW-1:0]) ? r_a[DW-1:0] : r_b[DW-1:0];

  always_comb begin
    w_res = w_max;
    if (i_s1_zo)        w_res = i_s1_zp;
    else if (i_s1_mode) w_res = DW'(w_sum >> 2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else begin
      if (i_ld1) begin
        r_a <= w_a;
        r_b <= w_b;
      end
      if (i_ld2) r_res <= w_res;
    end
  end

  assign o_res = r_res;
endmodule

module module_pool_array #(
  parameter int CH = 8,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*4*DW-1:0] ifm_win2x2,
  input  logic               pool_mode,
  input  logic               pool_zero_out,
  input  logic [DW-1:0]      zero_point,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH*DW-1:0]   ofm_stream
);
  logic          w_en, w_ld1, w_ld2;
  logic [1:0]    r_vld_pipe;   // [0] = S1 valid, [1] = S2 valid
  logic          r_s1_mode, r_s1_zo;
  logic [DW-1:0] r_s1_zp;

  // Whole pipe advances together; bubbles are overwritten, never stall.
  assign w_en      = out_ready || !r_vld_pipe[1];
  assign in_ready  = w_en;
  assign out_valid = r_vld_pipe[1];
  // Data registers only load for real beats so idle outputs stay quiet.
  assign w_ld1     = w_en && in_valid && !rst;
  assign w_ld2     = w_en && r_vld_pipe[0] && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s1_mode  <= 1'b0;
      r_s1_zo    <= 1'b0;
      r_s1_zp    <= '0;
    end else begin
      if (w_en) r_vld_pipe <= {r_vld_pipe[0], in_valid};
      if (w_ld1) begin
        r_s1_mode <= pool_mode;
        r_s1_zo   <= pool_zero_out;
        r_s1_zp   <= zero_point;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    module_pool_lane #(.DW(DW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_ld1    (w_ld1),
      .i_ld2    (w_ld2),
      .i_win    (ifm_win2x2[c*4*DW +: 4*DW]),
      .i_mode   (pool_mode),
      .i_s1_mode(r_s1_mode),
      .i_s1_zo  (r_s1_zo),
      .i_s1_zp  (r_s1_zp),
      .o_res    (ofm_stream[c*DW +: DW])
    );
  end
endmodule

// File: tb/tb_module_pool_array.sv
module tb_module_pool_array;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // ---------------- main DUT, CH=8 DW=8 ----------------
  logic         in_valid, out_ready, mode, zo;
  logic [7:0]   zp;
  logic [255:0] win;
  logic         in_ready, out_valid;
  logic [63:0]  ofm;

  module_pool_array #(.CH(8), .DW(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ifm_win2x2(win), .pool_mode(mode), .pool_zero_out(zo), .zero_point(zp),
    .out_valid(out_valid), .out_ready(out_ready), .ofm_stream(ofm));

  // ---------------- parameter sweep DUTs (lockstep) ----------------
  localparam int SW_CH [4] = '{1, 16, 64, 16};
  localparam int SW_DW [4] = '{8, 8, 12, 12};
  logic          sw_in_valid, sw_out_ready, sw_mode, sw_zo;
  logic [11:0]   sw_zp;
  logic [3071:0] sw_win;
  logic [3:0]    s_ir, s_ov;
  logic [7:0]    s0_ofm;
  logic [127:0]  s1_ofm;
  logic [767:0]  s2_ofm;
  logic [191:0]  s3_ofm;
  logic [767:0]  so [4];

  module_pool_array #(.CH(1), .DW(8)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(s_ir[0]),
    .ifm_win2x2(sw_win[31:0]), .pool_mode(sw_mode), .pool_zero_out(sw_zo),
    .zero_point(sw_zp[7:0]), .out_valid(s_ov[0]), .out_ready(sw_out_ready),
    .ofm_stream(s0_ofm));
  module_pool_array #(.CH(16), .DW(8)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(s_ir[1]),
    .ifm_win2x2(sw_win[511:0]), .pool_mode(sw_mode), .pool_zero_out(sw_zo),
    .zero_point(sw_zp[7:0]), .out_valid(s_ov[1]), .out_ready(sw_out_ready),
    .ofm_stream(s1_ofm));
  module_pool_array #(.CH(64), .DW(12)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(s_ir[2]),
    .ifm_win2x2(sw_win[3071:0]), .pool_mode(sw_mode), .pool_zero_out(sw_zo),
    .zero_point(sw_zp[11:0]), .out_valid(s_ov[2]), .out_ready(sw_out_ready),
    .ofm_stream(s2_ofm));
  module_pool_array #(.CH(16), .DW(12)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(s_ir[3]),
    .ifm_win2x2(sw_win[767:0]), .pool_mode(sw_mode), .pool_zero_out(sw_zo),
    .zero_point(sw_zp[11:0]), .out_valid(s_ov[3]), .out_ready(sw_out_ready),
    .ofm_stream(s3_ofm));

  always_comb begin
    so[0] = 768'(s0_ofm);
    so[1] = 768'(s1_ofm);
    so[2] = s2_ofm;
    so[3] = 768'(s3_ofm);
  end

  typedef struct {
    logic [3071:0] win;
    logic          mode;
    logic          zo;
    logic [11:0]   zp;
  } beat_t;
  beat_t q[$];

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rep_win(input logic [31:0] w);
    logic [255:0] r;
    for (int c = 0; c < 8; c++) r[c*32 +: 32] = w;
    return r;
  endfunction

  function automatic logic [63:0] rep_b(input logic [7:0] b);
    logic [63:0] r;
    for (int c = 0; c < 8; c++) r[c*8 +: 8] = b;
    return r;
  endfunction

  // Reference pooling for any CH/DW up to 64/12.
  function automatic logic [767:0] ref_pool(input logic [3071:0] w, input int ch,
      input int dw, input logic md, input logic z, input logic [11:0] zpv);
    logic [767:0]  r, tmp;
    logic [3071:0] t;
    int p [4];
    int res, mask;
    mask = (1 << dw) - 1;
    r = '0;
    for (int c = 0; c < ch; c++) begin
      for (int k = 0; k < 4; k++) begin
        t = w >> ((c*4 + k) * dw);
        p[k] = int'(t[11:0]) & mask;
      end
      if (z)       res = int'(zpv) & mask;
      else if (md) res = (p[0] + p[1] + p[2] + p[3] + 2) >> 2;
      else begin
        res = p[0];
        for (int k = 1; k < 4; k++) if (p[k] > res) res = p[k];
      end
      tmp = '0;
      tmp[11:0] = res[11:0];
      r = r | (tmp << (c*dw));
    end
    return r;
  endfunction

  task automatic rand_main_win();
    for (int i = 0; i < 8; i++) win[i*32 +: 32] = $urandom;
  endtask

  // One isolated beat: checks acceptance, exact 2-cycle latency and data.
  // Inputs are scrambled right after acceptance to prove per-beat capture.
  task automatic send_one(input string tag, input logic [31:0] w, input logic md,
      input logic z, input logic [7:0] zpv, input logic [7:0] exp);
    win = rep_win(w); mode = md; zo = z; zp = zpv;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); chk({tag, " in_ready"}, 768'(in_ready), 768'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; rand_main_win(); mode = ~md; zo = ~z; zp = ~zpv;
    @(negedge clk); chk({tag, " valid@+1"}, 768'(out_valid), 768'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " valid@+2"}, 768'(out_valid), 768'(1));
    chk({tag, " data"}, 768'(ofm), 768'(rep_b(exp)));
    @(posedge clk); #1;
    zo = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] bp_win [10];
  logic [63:0]  bp_exp [10];
  logic [63:0]  snap;
  logic         have_snap;
  logic [767:0] tmpw;
  int           sent, rcv;
  logic         en, m_v1, m_v2;
  beat_t        b;

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; mode = 1'b0; zo = 1'b0; zp = '0;
    win = rep_win(32'h11223344);
    sw_in_valid = 1'b0; sw_out_ready = 1'b1; sw_mode = 1'b0; sw_zo = 1'b0;
    sw_zp = '0; sw_win = '0;

    // Reset state; beat offered during reset must be dropped.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 768'(in_ready), 768'(1));
    chk("rst out_valid", 768'(out_valid), 768'(0));
    chk("rst ofm", 768'(ofm), 768'(0));
    chk("rst sweep out_valid", 768'(s_ov), 768'(0));
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("rst beat dropped", 768'(out_valid), 768'(0));
      @(posedge clk); #1;
    end

    // Max and average directed windows.
    send_one("max", 32'h037F8010, 1'b0, 1'b0, 8'h00, 8'h80);
    send_one("avg full", 32'hFEFFFFFF, 1'b1, 1'b0, 8'h00, 8'hFF);
    send_one("avg half-up", 32'h00000101, 1'b1, 1'b0, 8'h00, 8'h01);
    send_one("avg quarter", 32'h00000001, 1'b1, 1'b0, 8'h00, 8'h00);

    // Padding override in both modes, then a normal beat.
    send_one("zo max", $urandom, 1'b0, 1'b1, 8'h80, 8'h80);
    send_one("zo avg", $urandom, 1'b1, 1'b1, 8'h80, 8'h80);
    send_one("after zo", 32'h07020905, 1'b0, 1'b0, 8'h80, 8'h09);

    // Back-pressure: 10 beats, mode toggling, out_ready low cycles 4-7.
    for (int bb = 0; bb < 10; bb++) begin
      for (int c = 0; c < 8; c++)
        for (int k = 0; k < 4; k++)
          bp_win[bb][(c*4 + k)*8 +: 8] = 8'((bb*37 + c*11 + k*53) & 255);
      tmpw = ref_pool(3072'(bp_win[bb]), 8, 8, bb[0], 1'b0, 12'h0);
      bp_exp[bb] = tmpw[63:0];
    end
    sent = 0; rcv = 0; have_snap = 1'b0;
    for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid  = (sent < 10);
      if (sent < 10) begin win = bp_win[sent]; mode = sent[0]; end
      zo = 1'b0; zp = 8'($urandom);
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk("bp stall in_ready", 768'(in_ready), 768'(0));
        if (have_snap) chk("bp stall hold", 768'(ofm), 768'(snap));
        snap = ofm; have_snap = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (rcv < 10) chk($sformatf("bp beat%0d", rcv), 768'(ofm), 768'(bp_exp[rcv]));
        rcv++;
        have_snap = 1'b0;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    chk("bp sent", 768'(sent), 768'(10));
    chk("bp received", 768'(rcv), 768'(10));
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("bp no duplicate", 768'(out_valid), 768'(0));
      @(posedge clk); #1;
    end

    // Reset with two beats in flight (held by back-pressure).
    out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0; win = rep_win(32'h55555555);
    @(negedge clk); chk("mid-rst accept0", 768'(in_ready), 768'(1));
    @(posedge clk); #1;
    win = rep_win(32'h66666666);
    @(negedge clk); chk("mid-rst accept1", 768'(in_ready), 768'(1));
    @(posedge clk); #1;
    win = rep_win(32'h77777777); rst = 1'b1;
    @(negedge clk); chk("mid-rst pipe full", 768'(out_valid), 768'(1));
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mid-rst out_valid", 768'(out_valid), 768'(0));
    chk("mid-rst ofm", 768'(ofm), 768'(0));
    chk("mid-rst in_ready", 768'(in_ready), 768'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk); chk("mid-rst discarded", 768'(out_valid), 768'(0));
    end
    @(posedge clk); #1;
    send_one("post-rst", 32'h037F8010, 1'b0, 1'b0, 8'h00, 8'h80);

    // Parameter sweep with random traffic against the reference model.
    m_v1 = 1'b0; m_v2 = 1'b0;
    for (int k = 0; k < 420; k++) begin
      sw_in_valid  = (k < 400) && ($urandom_range(0, 3) != 0);
      sw_out_ready = (k >= 400) || ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 96; i++) sw_win[i*32 +: 32] = $urandom;
      sw_mode = 1'($urandom);
      sw_zo   = ($urandom_range(0, 7) == 0);
      sw_zp   = 12'($urandom);
      @(negedge clk);
      en = sw_out_ready || !m_v2;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("sw%0d in_ready", i), 768'(s_ir[i]), 768'(en));
        chk($sformatf("sw%0d out_valid", i), 768'(s_ov[i]), 768'(m_v2));
        if (m_v2 && q.size() > 0)
          chk($sformatf("sw%0d data", i), so[i],
              ref_pool(q[0].win, SW_CH[i], SW_DW[i], q[0].mode, q[0].zo, q[0].zp));
      end
      if (m_v2 && sw_out_ready && q.size() > 0) void'(q.pop_front());
      if (en) begin
        m_v2 = m_v1;
        m_v1 = sw_in_valid;
        if (sw_in_valid) begin
          b.win = sw_win; b.mode = sw_mode; b.zo = sw_zo; b.zp = sw_zp;
          q.push_back(b);
        end
      end
      @(posedge clk); #1;
    end
    chk("sw drained", 768'(q.size()), 768'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
